// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared widths and grant encoding for the register-file writeback arbiter.
package rf_writeback_arbiter_pkg;
  localparam int XLEN      = 64;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;
endpackage

// File: rtl/rf_writeback_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. req[0]/gnt[0] is the ALU and req[1]/gnt[1] is MEM.
module rr_arb2
  import rf_writeback_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_e r_last_grant;

  // Grant is a function of req and r_last_grant only. Every grant is a
  // transfer, because a requester is granted only while it is valid.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_last_grant == GRANT_MEM) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Resetting to MEM means the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= GRANT_MEM;
    end else if (gnt[0]) begin
      r_last_grant <= GRANT_ALU;
    end else if (gnt[1]) begin
      r_last_grant <= GRANT_MEM;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges the ALU and load writeback ports into one register-file write port,
// and keeps a pending-write scoreboard that drives the hazard output.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int XLEN = rf_writeback_arbiter_pkg::XLEN,
  parameter int NREG = rf_writeback_arbiter_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 hazard,
  output logic [NREG-1:0]      busy_mask,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] WriteReg,
  output logic [XLEN-1:0]      WriteData
);

  logic [1:0]           w_gnt;
  logic                 w_xfer;
  logic [REG_IDX_W-1:0] w_rd;
  logic [XLEN-1:0]      w_data;
  logic [NREG-1:0]      w_busy_nxt;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({mem_valid, alu_valid}),
    .gnt (w_gnt)
  );

  assign alu_ready = w_gnt[0];
  assign mem_ready = w_gnt[1];
  assign w_xfer    = |w_gnt;
  assign w_rd      = w_gnt[1] ? mem_rd   : alu_rd;
  assign w_data    = w_gnt[1] ? mem_data : alu_data;

  // The set is applied after the clear, so a new producer of the same rd wins.
  always_comb begin
    w_busy_nxt = busy_mask;
    if (w_xfer && (w_rd != '0)) begin
      w_busy_nxt[w_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
  end

  // Hazard reads the registered mask, so a clear in this cycle is not forwarded.
  assign hazard = ((rs1 != '0) && busy_mask[rs1]) ||
                  ((rs2 != '0) && busy_mask[rs2]);

  // Write port stage. Writes to x0 are accepted but never reach the file.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      busy_mask <= '0;
    end else begin
      RegWrite  <= w_xfer && (w_rd != '0);
      busy_mask <= w_busy_nxt;
      if (w_xfer) begin
        WriteReg  <= w_rd;
        WriteData <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with hand-computed expectations.
module tb_rf_writeback_arbiter;
  import rf_writeback_arbiter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;
  logic                 alu_ready;
  logic                 mem_valid;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 mem_ready;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic                 hazard;
  logic [NREG-1:0]      busy_mask;
  logic                 RegWrite;
  logic [REG_IDX_W-1:0] WriteReg;
  logic [XLEN-1:0]      WriteData;

  int checks = 0;
  int errors = 0;

  rf_writeback_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard      (hazard),
    .busy_mask   (busy_mask),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rs1 = '0; rs2 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset, with requests present that must not be accepted
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 64'hBEEF;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    step();
    step();
    check("rst_regwrite", RegWrite, 0);
    check("rst_writereg", WriteReg, 0);
    check("rst_writedata", WriteData, 0);
    check("rst_busy", busy_mask, 0);
    rst = 1'b0;
    idle();

    // Contention: ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
    #1;
    check("cont1_alu_ready", alu_ready, 1);
    check("cont1_mem_ready", mem_ready, 0);
    step();
    check("cont1_wreg", WriteReg, 1);
    check("cont1_wdata", WriteData, 64'h11);
    check("cont2_alu_ready", alu_ready, 0);
    check("cont2_mem_ready", mem_ready, 1);
    step();
    check("cont2_regwrite", RegWrite, 1);
    check("cont2_wreg", WriteReg, 2);
    check("cont2_wdata", WriteData, 64'h22);
    check("cont3_alu_ready", alu_ready, 1);
    check("cont3_mem_ready", mem_ready, 0);
    step();
    check("cont3_wreg", WriteReg, 1);
    check("cont4_alu_ready", alu_ready, 0);
    check("cont4_mem_ready", mem_ready, 1);
    step();
    check("cont4_wreg", WriteReg, 2);
    idle();

    // Single ALU write of rd=5
    step();
    check("idle_regwrite", RegWrite, 0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    #1;
    check("single_alu_ready", alu_ready, 1);
    check("single_mem_ready", mem_ready, 0);
    step();
    idle();
    check("single_regwrite", RegWrite, 1);
    check("single_wreg", WriteReg, 5);
    check("single_wdata", WriteData, 64'h1234);
    step();
    check("single_regwrite_off", RegWrite, 0);

    // Scoreboard: issue rd=7
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle();
    rs1 = 5'd7;
    #1;
    check("sb_busy7", busy_mask, 64'h80);
    check("sb_hazard_rs1", hazard, 1);
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    check("sb_hazard_rs2", hazard, 1);
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check("sb_hazard_x0", hazard, 0);

    // x0 write from MEM: accepted, no register write, mask unchanged
    rs1 = 5'd7;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hFF;
    #1;
    check("x0_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0; mem_data = '0;
    check("x0_regwrite", RegWrite, 0);
    check("x0_busy", busy_mask, 64'h80);
    check("x0_hazard", hazard, 1);

    // ALU writeback of rd=7: hazard stays until the following cycle
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    #1;
    check("wb7_alu_ready", alu_ready, 1);
    check("wb7_hazard_same_cycle", hazard, 1);
    step();
    alu_valid = 1'b0;
    check("wb7_regwrite", RegWrite, 1);
    check("wb7_wreg", WriteReg, 7);
    check("wb7_hazard_after", hazard, 0);
    check("wb7_busy", busy_mask, 0);
    idle();

    // Same-cycle set and clear of rd=3
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    check("sc_busy3_set", busy_mask, 64'h8);
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h33;
    #1;
    check("sc_mem_ready", mem_ready, 1);
    step();
    issue_valid = 1'b0; issue_rd = '0;
    check("sc_busy3_kept", busy_mask, 64'h8);
    check("sc_regwrite", RegWrite, 1);
    check("sc_wreg", WriteReg, 3);
    step();
    idle();
    check("sc_busy3_cleared", busy_mask, 0);

    // Reset in the cycle after an ALU transfer
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'hAA;
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    idle();
    check("mid_regwrite_pending", RegWrite, 1);
    check("mid_busy4", busy_mask, 64'h10);
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h2;
    #1;
    check("mid_rst_alu_ready", alu_ready, 0);
    check("mid_rst_mem_ready", mem_ready, 0);
    step();
    rst = 1'b0;
    check("mid_rst_regwrite", RegWrite, 0);
    check("mid_rst_busy", busy_mask, 0);
    check("mid_rst_wdata", WriteData, 0);
    #1;
    check("post_rst_tie_alu", alu_ready, 1);
    check("post_rst_tie_mem", mem_ready, 0);
    step();
    idle();
    check("post_rst_wreg", WriteReg, 1);
    check("post_rst_wdata", WriteData, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
